// File: rtl/fft_addr_pkg.sv
// Shared types and defaults for the FFT operand address sequencer.
// Optional write-back phase is enabled by OPERAND_ADDR_SEQ_WRITEBACK_EN.
package fft_addr_pkg;

    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_NUM_OPS = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT_RES,
        ST_WRITE,
        ST_DONE
    } seq_state_t;

    // Never returns zero so a slot index stays a legal vector width.
    function automatic int slot_width(input int num_ops);
        return (num_ops > 1) ? $clog2(num_ops) : 1;
    endfunction

endpackage

// File: rtl/operand_address_sequencer_if.sv
// Sequencer bus: start/operand request from the address generator and
// the SRAM address handshake. Master = sequencer, slave = its environment.
interface operand_address_sequencer_if #(
    parameter int ADDR_W  = fft_addr_pkg::DEF_ADDR_W,
    parameter int NUM_OPS = fft_addr_pkg::DEF_NUM_OPS
) ();
    import fft_addr_pkg::*;

    localparam int SLOT_W = slot_width(NUM_OPS);

    logic                      start;
    logic [NUM_OPS*ADDR_W-1:0] op_addr;
    logic                      addr_ready;
    logic                      result_valid;
    logic [ADDR_W-1:0]         addr;
    logic                      addr_valid;
    logic                      addr_we;
    logic [SLOT_W-1:0]         slot;
    logic                      busy;
    logic                      done;

    modport master (
        input  start, op_addr, addr_ready, result_valid,
        output addr, addr_valid, addr_we, slot, busy, done
    );

    modport slave (
        output start, op_addr, addr_ready, result_valid,
        input  addr, addr_valid, addr_we, slot, busy, done
    );

endinterface

// File: rtl/operand_slot_mux.sv
// Combinational select of one operand address out of a packed set.
module operand_slot_mux
    import fft_addr_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NUM_OPS = DEF_NUM_OPS
) (
    input  logic [NUM_OPS*ADDR_W-1:0]       i_addrs,
    input  logic [slot_width(NUM_OPS)-1:0]  i_sel,
    output logic [ADDR_W-1:0]               o_addr
);
    localparam int SLOT_W = slot_width(NUM_OPS);

    always_comb begin
        o_addr = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (i_sel == SLOT_W'(k)) begin
                o_addr = i_addrs[k*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/operand_address_sequencer.sv
// Latches butterfly operand addresses on start and issues them one per SRAM
// handshake; OPERAND_ADDR_SEQ_WRITEBACK_EN adds a write-back replay phase.
module operand_address_sequencer
    import fft_addr_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NUM_OPS = DEF_NUM_OPS
) (
    input logic                          clk,
    input logic                          rst,
    operand_address_sequencer_if.master  bus
);
    localparam int                SLOT_W    = slot_width(NUM_OPS);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_OPS - 1);

    seq_state_t                r_state;
    logic [NUM_OPS*ADDR_W-1:0] r_latch;
    logic [ADDR_W-1:0]         r_addr;
    logic                      r_addr_valid;
    logic [SLOT_W-1:0]         r_slot;
    logic                      r_busy;
    logic                      r_done;

    logic                      w_accept_start;
    logic                      w_handshake;
    logic                      w_last;
    logic [SLOT_W-1:0]         w_sel;
    logic [NUM_OPS*ADDR_W-1:0] w_src;
    logic [ADDR_W-1:0]         w_mux_addr;

    // The mux looks one slot ahead so the address register loads the next
    // operand on the handshake edge; on start it reads op_addr directly.
    assign w_accept_start = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && bus.start;
    assign w_handshake    = r_addr_valid && bus.addr_ready;
    assign w_last         = (r_slot == LAST_SLOT);
    assign w_src          = w_accept_start ? bus.op_addr : r_latch;
    assign w_sel          = (w_handshake && !w_last) ? r_slot + 1'b1 : '0;

    operand_slot_mux #(
        .ADDR_W  (ADDR_W),
        .NUM_OPS (NUM_OPS)
    ) u_slot_mux (
        .i_addrs (w_src),
        .i_sel   (w_sel),
        .o_addr  (w_mux_addr)
    );

`ifdef OPERAND_ADDR_SEQ_WRITEBACK_EN
    logic r_addr_we;
    assign bus.addr_we = r_addr_we;
`else
    logic w_unused_result_valid;
    assign w_unused_result_valid = bus.result_valid;
    assign bus.addr_we           = 1'b0;
`endif

    assign bus.addr       = r_addr;
    assign bus.addr_valid = r_addr_valid;
    assign bus.slot       = r_slot;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_latch      <= '0;
            r_addr       <= '0;
            r_addr_valid <= 1'b0;
            r_slot       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef OPERAND_ADDR_SEQ_WRITEBACK_EN
            r_addr_we    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_state      <= ST_READ;
                        r_latch      <= bus.op_addr;
                        r_addr       <= w_mux_addr;
                        r_addr_valid <= 1'b1;
                        r_slot       <= '0;
                        r_busy       <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (w_handshake) begin
                        if (w_last) begin
                            r_addr       <= '0;
                            r_addr_valid <= 1'b0;
                            r_slot       <= '0;
`ifdef OPERAND_ADDR_SEQ_WRITEBACK_EN
                            r_state      <= ST_WAIT_RES;
`else
                            r_state      <= ST_DONE;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
`endif
                        end else begin
                            r_addr <= w_mux_addr;
                            r_slot <= w_sel;
                        end
                    end
                end
`ifdef OPERAND_ADDR_SEQ_WRITEBACK_EN
                // Only a result_valid seen after the read phase starts write-back.
                ST_WAIT_RES: begin
                    if (bus.result_valid) begin
                        r_state      <= ST_WRITE;
                        r_addr       <= w_mux_addr;
                        r_addr_valid <= 1'b1;
                        r_addr_we    <= 1'b1;
                        r_slot       <= '0;
                    end
                end
                ST_WRITE: begin
                    if (w_handshake) begin
                        if (w_last) begin
                            r_state      <= ST_DONE;
                            r_addr       <= '0;
                            r_addr_valid <= 1'b0;
                            r_addr_we    <= 1'b0;
                            r_slot       <= '0;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                        end else begin
                            r_addr <= w_mux_addr;
                            r_slot <= w_sel;
                        end
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
